wb_arb: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_arb_pick.sv | 33 +++
 rtl/wb_arb.sv | 163 ++++++++++++++++
 tb/tb_wb_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the Wishbone arbiter.
//   clog2          - ceiling log2 used for index, address and counter widths
//   wb_arb_state_e - arbiter FSM encoding (IDLE = 0, GRANT = 1)
package wb_arb_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  typedef enum logic {
    WB_ARB_IDLE  = 1'b0,
    WB_ARB_GRANT = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_arb_pick.sv
// wb_arb_pick: combinational winner select.
// Scans the request vector starting at index 'start' and wrapping around;
// the first set request wins.
//   req   in  MASTERCOUNT : request vector (master i at bit i)
//   start in  IDXW        : first index examined
//   idx   out IDXW        : winning index (0 when no request)
//   vld   out 1           : at least one request is set
module wb_arb_pick
  import wb_arb_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  parameter int IDXW        = clog2(MASTERCOUNT)
) (
  input  logic [MASTERCOUNT-1:0] req,
  input  logic [IDXW-1:0]        start,
  output logic [IDXW-1:0]        idx,
  output logic                   vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      int j;
      j = (int'(start) + k) % MASTERCOUNT;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: multi-master pipelined Wishbone arbiter.
// Grants one master at a time and forwards its requests to the single slave
// port. The grant is held for as long as the owner keeps cyc high; a counter
// of accepted-but-unacknowledged requests throttles the owner at MAXPENDING
// and filters stray acks.
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) and no pointer register.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   m_wb_*  : packed per-master Wishbone ports, master i at slice i
//   s_wb_*  : downstream Wishbone master port
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int ARCHBITSZ   = 16,
  parameter int MASTERCOUNT = 2,
  parameter int MAXPENDING  = 4,
  localparam int SELW       = ARCHBITSZ / 8,
  localparam int ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
  input  logic                             rst_i,
  input  logic                             clk_i,
  input  logic [MASTERCOUNT-1:0]           m_wb_cyc_i,
  input  logic [MASTERCOUNT-1:0]           m_wb_stb_i,
  input  logic [MASTERCOUNT-1:0]           m_wb_we_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_wb_addr_i,
  input  logic [SELW*MASTERCOUNT-1:0]      m_wb_sel_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_wb_dat_i,
  output logic [MASTERCOUNT-1:0]           m_wb_bsy_o,
  output logic [MASTERCOUNT-1:0]           m_wb_ack_o,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_wb_dat_o,
  output logic                             s_wb_cyc_o,
  output logic                             s_wb_stb_o,
  output logic                             s_wb_we_o,
  output logic [ADDRBITSZ-1:0]             s_wb_addr_o,
  output logic [SELW-1:0]                  s_wb_sel_o,
  output logic [ARCHBITSZ-1:0]             s_wb_dat_o,
  input  logic                             s_wb_bsy_i,
  input  logic                             s_wb_ack_i,
  input  logic [ARCHBITSZ-1:0]             s_wb_dat_i
);

  localparam int IDXW  = clog2(MASTERCOUNT);
  localparam int PENDW = clog2(MAXPENDING + 1);

  wb_arb_state_e    state_q, state_d;
  logic [IDXW-1:0]  gntidx_q, gntidx_d;
  logic [PENDW-1:0] pending_q, pending_d;

  logic [IDXW-1:0]  pick_start;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_vld;

  logic             granted;
  logic             full;
  logic             stb_fwd;
  logic             accept;
  logic             ack_cnt;

  function automatic logic [PENDW-1:0] next_pending(input logic [PENDW-1:0] cur,
                                                    input logic inc,
                                                    input logic dec);
    case ({inc, dec})
      2'b10:   return cur + PENDW'(1);
      2'b01:   return cur - PENDW'(1);
      default: return cur;
    endcase
  endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_start = rr_ptr_q;

  // Next search begins just past the master being granted now.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == WB_ARB_IDLE && pick_vld) begin
      if (pick_idx == IDXW'(MASTERCOUNT - 1)) rr_ptr_d = '0;
      else                                    rr_ptr_d = pick_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_start = '0;
`endif

  wb_arb_pick #(
    .MASTERCOUNT (MASTERCOUNT),
    .IDXW        (IDXW)
  ) u_pick (
    .req   (m_wb_cyc_i),
    .start (pick_start),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  assign granted = (state_q == WB_ARB_GRANT);
  assign full    = (pending_q == PENDW'(MAXPENDING));
  assign stb_fwd = granted && m_wb_stb_i[gntidx_q] && !full;
  assign accept  = stb_fwd && !s_wb_bsy_i;
  // Acks with nothing outstanding are dropped so the counter cannot wrap.
  assign ack_cnt = granted && s_wb_ack_i && (pending_q != '0);

  always_comb begin
    state_d   = state_q;
    gntidx_d  = gntidx_q;
    pending_d = pending_q;
    case (state_q)
      WB_ARB_IDLE: begin
        if (pick_vld) begin
          state_d   = WB_ARB_GRANT;
          gntidx_d  = pick_idx;
          pending_d = '0;
        end
      end
      WB_ARB_GRANT: begin
        // Owner dropping cyc is an abort: outstanding count is discarded.
        if (!m_wb_cyc_i[gntidx_q]) begin
          state_d   = WB_ARB_IDLE;
          pending_d = '0;
        end else begin
          pending_d = next_pending(pending_q, accept, ack_cnt);
        end
      end
      default: state_d = WB_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= WB_ARB_IDLE;
      gntidx_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      gntidx_q  <= gntidx_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    m_wb_bsy_o = '1;
    m_wb_ack_o = '0;
    s_wb_cyc_o = granted && m_wb_cyc_i[gntidx_q];
    s_wb_stb_o = stb_fwd;
    if (granted) begin
      m_wb_bsy_o[gntidx_q] = s_wb_bsy_i || full;
      m_wb_ack_o[gntidx_q] = ack_cnt;
    end
  end

  assign s_wb_we_o   = m_wb_we_i[gntidx_q];
  assign s_wb_addr_o = m_wb_addr_i[int'(gntidx_q)*ADDRBITSZ +: ADDRBITSZ];
  assign s_wb_sel_o  = m_wb_sel_i[int'(gntidx_q)*SELW +: SELW];
  assign s_wb_dat_o  = m_wb_dat_i[int'(gntidx_q)*ARCHBITSZ +: ARCHBITSZ];
  assign m_wb_dat_o  = {MASTERCOUNT{s_wb_dat_i}};

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: directed bench for wb_arb (ARCHBITSZ=16, MASTERCOUNT=2,
// MAXPENDING=4). Expectations follow WB_ARB_ROUND_ROBIN_EN when defined.
module tb_wb_arb;

  localparam int AW = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  cyc, stb, we;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [1:0]  m_bsy, m_ack;
  logic [31:0] m_dat;
  logic        s_cyc, s_stb, s_we;
  logic [14:0] s_addr;
  logic [1:0]  s_sel;
  logic [15:0] s_wdat;
  logic        s_bsy, s_ack;
  logic [15:0] s_rdat;

  int n_chk  = 0;
  int n_pass = 0;
  int acc;
  logic [1:0] exp_bsy;
  logic [1:0] cyc_drop;

  wb_arb #(
    .ARCHBITSZ   (16),
    .MASTERCOUNT (2),
    .MAXPENDING  (4)
  ) dut (
    .rst_i       (rst_i),
    .clk_i       (clk_i),
    .m_wb_cyc_i  (cyc),
    .m_wb_stb_i  (stb),
    .m_wb_we_i   (we),
    .m_wb_addr_i (addr),
    .m_wb_sel_i  (sel),
    .m_wb_dat_i  (wdat),
    .m_wb_bsy_o  (m_bsy),
    .m_wb_ack_o  (m_ack),
    .m_wb_dat_o  (m_dat),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_we_o   (s_we),
    .s_wb_addr_o (s_addr),
    .s_wb_sel_o  (s_sel),
    .s_wb_dat_o  (s_wdat),
    .s_wb_bsy_i  (s_bsy),
    .s_wb_ack_i  (s_ack),
    .s_wb_dat_i  (s_rdat)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0; cyc = '0; stb = '0; we = '0; addr = '0; sel = '1; wdat = '0;
    s_bsy = 1'b0; s_ack = 1'b0; s_rdat = '0;

    // Reset held with every master requesting
    cyc = 2'b11;
    step(); step();
    #1;
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_bsy",   32'(m_bsy), 32'b11);
    chk("rst_ack",   32'(m_ack), 32'b00);
    rst_i = 1'b1;
    step(); #1;
    chk("rst_grant_m0_bsy", 32'(m_bsy), 32'b10);
    chk("rst_grant_s_cyc",  32'(s_cyc), 32'd1);
    cyc = 2'b00;
    step(); #1;
    chk("release_idle_s_cyc", 32'(s_cyc), 32'd0);

    // Single read from master 1
    cyc = 2'b10;
    step();
    stb = 2'b10; addr[AW +: AW] = 15'h123; we = 2'b00;
    #1;
    chk("rd_s_stb",  32'(s_stb),  32'd1);
    chk("rd_s_addr", 32'(s_addr), 32'h123);
    chk("rd_bsy",    32'(m_bsy),  32'b01);
    step();
    stb = 2'b00;
    step();
    s_ack = 1'b1; s_rdat = 16'hBEEF;
    #1;
    chk("rd_ack",    32'(m_ack),        32'b10);
    chk("rd_dat_m1", 32'(m_dat[31:16]), 32'hBEEF);
    chk("rd_dat_m0", 32'(m_dat[15:0]),  32'hBEEF);
    step();
    s_ack = 1'b0;
    #1;
    chk("rd_ack_done", 32'(m_ack), 32'b00);
    cyc = 2'b00;
    step();

    // Pending limit: master 0 streams 6 stb, slave never acks
    cyc = 2'b01;
    step();
    stb = 2'b01; acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (s_stb && !s_bsy) acc++;
      step();
    end
    chk("lim_accepts", 32'(acc), 32'd4);
    #1;
    chk("lim_bsy_full", 32'(m_bsy), 32'b11);
    chk("lim_s_stb",    32'(s_stb), 32'd0);
    stb = 2'b00; s_ack = 1'b1;
    #1;
    chk("lim_ack_fwd", 32'(m_ack), 32'b01);
    step();
    s_ack = 1'b0;
    #1;
    chk("lim_pending_3",   32'(dut.pending_q), 32'd3);
    chk("lim_bsy_release", 32'(m_bsy),         32'b10);
    s_ack = 1'b1;
    step();
    // Accept and ack together with pending = 2
    stb = 2'b01; s_ack = 1'b1;
    #1;
    chk("both_s_stb", 32'(s_stb), 32'd1);
    chk("both_ack",   32'(m_ack), 32'b01);
    step();
    stb = 2'b00; s_ack = 1'b0;
    #1;
    chk("both_pending_2", 32'(dut.pending_q), 32'd2);
    s_ack = 1'b1;
    step(); step();
    // Stray ack with nothing outstanding
    #1;
    chk("spur_ack_dropped", 32'(m_ack), 32'b00);
    step();
    s_ack = 1'b0;
    #1;
    chk("spur_no_underflow", 32'(dut.pending_q), 32'd0);

    // Abort with 3 outstanding, master 1 waiting
    stb = 2'b01; cyc = 2'b11;
    step(); step(); step();
    stb = 2'b00;
    #1;
    chk("abort_pending_3", 32'(dut.pending_q), 32'd3);
    chk("abort_m1_waits",  32'(m_bsy),         32'b10);
    cyc = 2'b10;
    step(); #1;
    chk("abort_idle_s_cyc", 32'(s_cyc), 32'd0);
    chk("abort_idle_bsy",   32'(m_bsy), 32'b11);
    step(); #1;
    chk("abort_m1_grant",   32'(m_bsy),         32'b01);
    chk("abort_pending_0",  32'(dut.pending_q), 32'd0);
    cyc = 2'b00;
    step();

    // Arbitration: both request together
    cyc = 2'b11;
    step(); #1;
    chk("arb_first_m0", 32'(m_bsy), 32'b10);
    stb = 2'b01;
    step(); step(); step();
    stb = 2'b00; s_ack = 1'b1;
    #1;
    chk("arb_m0_ack", 32'(m_ack), 32'b01);
    step(); step(); step();
    s_ack = 1'b0;
    cyc = 2'b10;
    step();
    cyc = 2'b11;
    step(); #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_bsy = 2'b01;
    cyc_drop = 2'b01;
`else
    exp_bsy = 2'b10;
    cyc_drop = 2'b10;
`endif
    chk("arb_second", 32'(m_bsy), 32'(exp_bsy));
    cyc = cyc_drop;
    step();
    cyc = 2'b11;
    step(); #1;
    chk("arb_third_m0", 32'(m_bsy), 32'b10);
    cyc = 2'b00;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
